// File: rtl/cnn1d_pkg.sv
// Shared helpers for the 1D-CNN datapath blocks.
// Provides a constant-evaluable ceiling log2 for sizing counters.
package cnn1d_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/s2p.sv
// Serial-to-parallel converter: gathers NUM_ELEMENTS serial beats into one parallel
// output beat, with valid/ready handshakes on both sides and a double-buffered vector.
module s2p
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH   = 12,
    parameter int NUM_ELEMENTS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  s2p_ready_in,
    input  logic                  s2p_valid_in,
    input  logic [DATA_WIDTH-1:0] s2p_serial_in,
    input  logic                  s2p_ready_out,
    output logic                  s2p_valid_out,
    output logic [DATA_WIDTH-1:0] s2p_parallel_out [0:NUM_ELEMENTS-1]
);

    // Handshakes: a beat transfers on a rising clk edge where valid and ready are
    // both high; valid never waits on ready, and data is held while valid is unaccepted.

    localparam int CW = (clog2(NUM_ELEMENTS) < 1) ? 1 : clog2(NUM_ELEMENTS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_ELEMENTS - 1);

    // FILLING accepts beats; BLOCKED holds a completed vector waiting for the slot.
    typedef enum logic {
        FILLING = 1'b0,
        BLOCKED = 1'b1
    } fill_state_t;

    fill_state_t           state, state_next;
    logic [CW-1:0]         count, count_next;
    logic                  valid_next;
    logic                  take;
    logic                  slot_free;
    logic                  load_direct;
    logic                  load_blocked;
    logic [DATA_WIDTH-1:0] collect [0:NUM_ELEMENTS-1];

    assign s2p_ready_in = (state == FILLING);
    assign take         = s2p_valid_in && s2p_ready_in;
    assign slot_free    = !s2p_valid_out || s2p_ready_out;

    always_comb begin
        state_next   = state;
        count_next   = count;
        valid_next   = s2p_valid_out && !s2p_ready_out;
        load_direct  = 1'b0;
        load_blocked = 1'b0;

        if (take) begin
            count_next = (count == LAST_IDX) ? '0 : count + 1'b1;
        end

        case (state)
            FILLING: begin
                if (take && (count == LAST_IDX)) begin
                    if (slot_free) begin
                        load_direct = 1'b1;
                        valid_next  = 1'b1;
                    end else begin
                        state_next = BLOCKED;
                    end
                end
            end
            BLOCKED: begin
                if (slot_free) begin
                    load_blocked = 1'b1;
                    valid_next   = 1'b1;
                    state_next   = FILLING;
                end
            end
            default: state_next = FILLING;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FILLING;
            count         <= '0;
            s2p_valid_out <= 1'b0;
            for (int k = 0; k < NUM_ELEMENTS; k++) begin
                collect[k]          <= '0;
                s2p_parallel_out[k] <= '0;
            end
        end else begin
            state         <= state_next;
            count         <= count_next;
            s2p_valid_out <= valid_next;
            if (take) begin
                collect[count] <= s2p_serial_in;
            end
            // The final element bypasses collect so the vector leaves one cycle after it.
            if (load_direct) begin
                for (int k = 0; k < NUM_ELEMENTS; k++) begin
                    if (k == NUM_ELEMENTS - 1) begin
                        s2p_parallel_out[k] <= s2p_serial_in;
                    end else begin
                        s2p_parallel_out[k] <= collect[k];
                    end
                end
            end else if (load_blocked) begin
                for (int k = 0; k < NUM_ELEMENTS; k++) begin
                    s2p_parallel_out[k] <= collect[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_s2p.sv
// Directed bench for s2p (DATA_WIDTH=12, NUM_ELEMENTS=5) with a vector scoreboard.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_s2p;

    localparam int DW = 12;
    localparam int NE = 5;

    logic          clk;
    logic          rst;
    logic          s2p_ready_in;
    logic          s2p_valid_in;
    logic [DW-1:0] s2p_serial_in;
    logic          s2p_ready_out;
    logic          s2p_valid_out;
    logic [DW-1:0] s2p_parallel_out [0:NE-1];
    logic [DW*NE-1:0] pflat;

    int n_cmp = 0;
    int n_bad = 0;
    int n_rx  = 0;
    logic [63:0] exp_q[$];
    logic drv_done;

    s2p #(.DATA_WIDTH(DW), .NUM_ELEMENTS(NE)) dut (
        .clk              (clk),
        .rst              (rst),
        .s2p_ready_in     (s2p_ready_in),
        .s2p_valid_in     (s2p_valid_in),
        .s2p_serial_in    (s2p_serial_in),
        .s2p_ready_out    (s2p_ready_out),
        .s2p_valid_out    (s2p_valid_out),
        .s2p_parallel_out (s2p_parallel_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        pflat = '0;
        for (int k = 0; k < NE; k++) pflat[k*DW +: DW] = s2p_parallel_out[k];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Vector of consecutive elements base, base+1, ..., element 0 in the low bits.
    function automatic logic [63:0] vec5(input int base);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < NE; k++) v[k*DW +: DW] = DW'(base + k);
        return v;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int data, output int stalls);
        logic taken;
        taken  = 1'b0;
        stalls = 0;
        s2p_valid_in  = 1'b1;
        s2p_serial_in = DW'(data);
        for (int w = 0; w < 200 && !taken; w++) begin
            taken = s2p_ready_in;
            if (!taken) stalls++;
            tick();
        end
        check("beat_taken", taken, 1);
    endtask

    // scoreboard: every vector consumed downstream must match the queue head
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && s2p_valid_out && s2p_ready_out) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("vec_data", pflat, e);
            end
            n_rx++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int stall_sum;
        logic [63:0] lit_1_5;

        rst           = 1'b1;
        s2p_valid_in  = 1'b0;
        s2p_serial_in = '0;
        s2p_ready_out = 1'b0;
        drv_done      = 1'b0;
        #1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid_out", s2p_valid_out, 0);
        check("rst_ready_in", s2p_ready_in, 1);
        check("rst_parallel", pflat, 0);

        // single vector, 1-cycle latency, valid for exactly one cycle
        s2p_ready_out = 1'b1;
        lit_1_5 = 64'h005_004_003_002_001;
        exp_q.push_back(lit_1_5);
        for (int i = 1; i <= 5; i++) begin
            send_beat(i, st);
            if (i == 4) check("t2_valid_before_last", s2p_valid_out, 0);
        end
        s2p_valid_in = 1'b0;
        check("t2_valid_after_last", s2p_valid_out, 1);
        check("t2_parallel", pflat, lit_1_5);
        tick();
        check("t2_valid_one_cycle", s2p_valid_out, 0);

        // continuous stream: no stalls, a vector every 5 cycles
        stall_sum = 0;
        exp_q.push_back(vec5(1));
        exp_q.push_back(vec5(6));
        exp_q.push_back(vec5(11));
        for (int i = 1; i <= 15; i++) begin
            send_beat(i, st);
            stall_sum += st;
            check("t3_valid_cadence", s2p_valid_out, (i % 5) == 0);
        end
        s2p_valid_in = 1'b0;
        check("t3_no_stall", stall_sum, 0);
        tick();

        // backpressure: second vector blocks, input stops
        s2p_ready_out = 1'b0;
        exp_q.push_back(vec5(1));
        exp_q.push_back(vec5(6));
        for (int i = 1; i <= 10; i++) send_beat(i, st);
        check("t4_ready_in_low", s2p_ready_in, 0);
        check("t4_valid_held", s2p_valid_out, 1);
        check("t4_held_data", pflat, vec5(1));
        s2p_valid_in  = 1'b1;
        s2p_serial_in = DW'(11);
        for (int c = 0; c < 3; c++) begin
            check("t4_beat11_refused", s2p_ready_in, 0);
            tick();
        end
        check("t4_still_held", pflat, vec5(1));
        s2p_valid_in  = 1'b0;
        s2p_ready_out = 1'b1;
        tick();
        check("t4_valid_transfer", s2p_valid_out, 1);
        check("t4_ready_in_back", s2p_ready_in, 1);
        check("t4_second_vec", pflat, vec5(6));
        tick();
        check("t4_valid_drop", s2p_valid_out, 0);
        check("t4_queue_empty", exp_q.size(), 0);

        // random gaps and random downstream readiness over 1..50
        for (int v = 0; v < 10; v++) exp_q.push_back(vec5(1 + v * 5));
        fork
            begin
                for (int i = 1; i <= 50; i++) begin
                    s2p_valid_in = 1'b0;
                    repeat ($urandom_range(0, 3)) tick();
                    send_beat(i, st);
                end
                s2p_valid_in = 1'b0;
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    s2p_ready_out = 1'($urandom_range(0, 1));
                    tick();
                end
                s2p_ready_out = 1'b1;
            end
        join
        for (int w = 0; w < 100 && exp_q.size() != 0; w++) tick();
        tick();
        check("t5_all_vectors_out", exp_q.size(), 0);
        check("t5_rx_count", n_rx, 16);
        check("t5_valid_idle", s2p_valid_out, 0);

        // reset discards a partial vector
        s2p_ready_out = 1'b1;
        for (int i = 7; i <= 9; i++) send_beat(i, st);
        s2p_valid_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_ready_in", s2p_ready_in, 1);
        check("t6_rst_valid", s2p_valid_out, 0);
        exp_q.push_back(vec5(20));
        for (int i = 20; i <= 24; i++) send_beat(i, st);
        s2p_valid_in = 1'b0;
        check("t6_valid", s2p_valid_out, 1);
        check("t6_parallel", pflat, vec5(20));
        tick();
        check("t6_queue_empty", exp_q.size(), 0);
        check("total_rx", n_rx, 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
